hamming_weight_accumulator: RTL
===============================

Name: hamming_weight_accumulator

Overview:
Multi-cycle, parametrised Hamming-weight engine. It counts set bits in a DATA_WIDTH word at CHUNK_WIDTH bits per clock, driven by a start/busy/done handshake. It also produces the word's parity (for ISO7816 character parity checks in the bench) and keeps a saturating running total across words. It serves as the test-side reference for bit-count and parity checks on received and transmitted characters.

Parameters:
DATA_WIDTH, 8, width of the input word.
CHUNK_WIDTH, 2, bits counted per clock. Must divide DATA_WIDTH. Defines N = DATA_WIDTH/CHUNK_WIDTH.
WEIGHT_WIDTH, 4, width of the per-word weight. Must be >= clog2(DATA_WIDTH+1).
ACC_WIDTH, 16, width of the running total.

Ports:
clk  input  1  single clock; all logic on the rising edge.
nReset  input  1  reset, synchronous, active-low.
dataIn  input  DATA_WIDTH  word to count. Sampled only on an accepted start.
start  input  1  request. Accepted only when busy=0.
accumulate  input  1  sampled with start. 1 = add this word's weight to accWeight.
clearAcc  input  1  synchronous clear of accWeight and accOverflow.
busy  output  1  high while counting.
done  output  1  one-cycle pulse when the result is valid.
hammingWeight  output  WEIGHT_WIDTH  popcount of the last completed word.
parity  output  1  XOR of all bits of the last completed word (= hammingWeight[0]).
accWeight  output  ACC_WIDTH  saturating sum of weights of accumulated words.
accOverflow  output  1  sticky saturation flag.

Behaviour:
- Reset: on the clk edge with nReset=0, all outputs go to 0 and the FSM goes to IDLE. Reset mid-run aborts the operation, and no done pulse is issued for that word.
- FSM states:
  - IDLE: busy=0. On start=1, capture dataIn into the shift register and accumulate into a flag, clear the working count and the chunk counter, go to RUN, busy=1.
  - RUN: each edge adds the popcount of the low CHUNK_WIDTH bits of the shift register to the working count, then shifts right by CHUNK_WIDTH and increments the chunk counter.
  - RUN exit: on the edge that processes chunk N-1, write the final sum to hammingWeight and its bit 0 to parity, pulse done=1 for one cycle, clear busy, and return to IDLE.
- Latency: start sampled at edge E0 gives done=1 during the cycle after edge E0+N. For N=4, done follows 4 edges after acceptance. CHUNK_WIDTH=DATA_WIDTH gives N=1.
- Throughput: a new start may be accepted in the same cycle done is high (FSM is in IDLE), so back-to-back words take N+1 cycles each.
- Ignored inputs: start while busy=1 is ignored, with no queueing. dataIn and accumulate changes during RUN are ignored.
- Output hold: hammingWeight and parity hold until the next completion. They are not cleared at start.
- Weight width: the working count is WEIGHT_WIDTH bits and wraps modulo 2^WEIGHT_WIDTH if the parameter rule is violated. No check is made for this.
- Accumulator update: on completion with the latched accumulate=1, accWeight = min(accWeight + hammingWeight_new, 2^ACC_WIDTH-1). If the true sum exceeds the maximum, accOverflow is set. accOverflow stays set until clearAcc or reset.
- clearAcc with no completion: accWeight=0 and accOverflow=0 on the next edge.
- clearAcc on the same edge as an accumulating completion: accWeight = new weight, and accOverflow = 0 unless the new weight alone saturates.
- clearAcc does not affect the FSM, hammingWeight, or parity.

Test Plan (all with default parameters unless noted):
1. Reset: hold nReset=0 for 2 edges, with start=1 during reset -> busy, done, hammingWeight, parity, accWeight, accOverflow all 0. No run starts.
2. Single word: dataIn=8'hB5, start pulse -> busy for 4 cycles, then done=1 for exactly one cycle with hammingWeight=5, parity=1. Also 8'hFF -> 8, parity 0; 8'h00 -> 0, parity 0.
3. Ignored inputs: start again and change dataIn to 8'h00 two cycles into a run of 8'h0F -> result 4, only one done pulse, no second run queued.
4. Accumulation:
   - three back-to-back 8'hFF words with accumulate=1 (each start issued in its predecessor's done cycle) -> accWeight 8, 16, 24; each done spaced 5 cycles apart.
   - a fourth word 8'h01 with accumulate=0 -> hammingWeight=1, accWeight stays 24.
5. Saturation with ACC_WIDTH=4: accumulate 8'hFF twice -> accWeight 8, then 15 with accOverflow=1. clearAcc -> 0/0. clearAcc coincident with a completion of 8'h07 -> accWeight=3, accOverflow=0.
6. Reset mid-run: nReset=0 at the 2nd edge of a run -> busy=0 next cycle, no done pulse. A following start of 8'h81 -> hammingWeight=2, parity=0.

Source files
------------

// File: rtl/hamming_weight_accumulator.sv
// Purpose : multi-cycle popcount of a DATA_WIDTH word, CHUNK_WIDTH bits per clock,
//           with word parity and a saturating running total of word weights.
// Latency : start accepted at edge E0 -> done pulses in the cycle after edge E0+N
//           (N = DATA_WIDTH/CHUNK_WIDTH); back-to-back words every N+1 cycles.
// Backpressure: none; start is accepted only while busy_o=0 (incl. the done cycle),
//           otherwise it is dropped without queueing.
//
// Ports:
//   clk_i            rising-edge clock
//   nReset_i         synchronous active-low reset (aborts a run, no done pulse)
//   dataIn_i         word to count, sampled on an accepted start
//   start_i          request, accepted when idle
//   accumulate_i     sampled with start; add this word's weight to accWeight_o
//   clearAcc_i       synchronous clear of accWeight_o / accOverflow_o
//   busy_o           high while counting
//   done_o           one-cycle pulse when hammingWeight_o/parity_o are updated
//   hammingWeight_o  popcount of the last completed word
//   parity_o         XOR of all bits of the last completed word
//   accWeight_o      saturating sum of accumulated word weights
//   accOverflow_o    sticky saturation flag
module hamming_weight_accumulator #(
  parameter int DATA_WIDTH   = 8,
  parameter int CHUNK_WIDTH  = 2,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ACC_WIDTH    = 16
) (
  input  logic                    clk_i,
  input  logic                    nReset_i,
  input  logic [DATA_WIDTH-1:0]   dataIn_i,
  input  logic                    start_i,
  input  logic                    accumulate_i,
  input  logic                    clearAcc_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [WEIGHT_WIDTH-1:0] hammingWeight_o,
  output logic                    parity_o,
  output logic [ACC_WIDTH-1:0]    accWeight_o,
  output logic                    accOverflow_o
);

  localparam int N      = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CIDX_W = (N > 1) ? $clog2(N) : 1;
  // One spare bit above the wider of accumulator/weight so the carry is visible.
  localparam int SUM_W  = ((ACC_WIDTH > WEIGHT_WIDTH) ? ACC_WIDTH : WEIGHT_WIDTH) + 1;

  localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(N - 1);
  localparam logic [SUM_W-1:0]  ACC_MAX    = (SUM_W'(1) << ACC_WIDTH) - SUM_W'(1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [WEIGHT_WIDTH-1:0] cnt_q;
  logic [CIDX_W-1:0]       chunk_q;
  logic                    acc_en_q;
  logic                    busy_q;
  logic                    done_q;
  logic [WEIGHT_WIDTH-1:0] hw_q;
  logic                    parity_q;
  logic [ACC_WIDTH-1:0]    acc_q;
  logic                    ovf_q;

  logic [WEIGHT_WIDTH-1:0] chunk_pop;
  logic [WEIGHT_WIDTH-1:0] weight_d;
  logic [ACC_WIDTH-1:0]    acc_base;
  logic                    ovf_base;
  logic [SUM_W-1:0]        acc_sum;
  logic                    acc_sat;
  logic [ACC_WIDTH-1:0]    acc_d;

  // Popcount of the chunk currently sitting in the low bits of the shifter.
  always_comb begin
    chunk_pop = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      chunk_pop = chunk_pop + WEIGHT_WIDTH'(shift_q[i]);
    end
  end

  // Working count wraps modulo 2^WEIGHT_WIDTH by construction.
  assign weight_d = cnt_q + chunk_pop;

  // A clear coinciding with a completion restarts the total from the new weight.
  always_comb begin
    acc_base = clearAcc_i ? '0 : acc_q;
    ovf_base = ~clearAcc_i & ovf_q;
    acc_sum  = SUM_W'(acc_base) + SUM_W'(weight_d);
    acc_sat  = (acc_sum > ACC_MAX);
    acc_d    = acc_sat ? ACC_MAX[ACC_WIDTH-1:0] : acc_sum[ACC_WIDTH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!nReset_i) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      chunk_q  <= '0;
      acc_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hw_q     <= '0;
      parity_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clearAcc_i) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            shift_q  <= dataIn_i;
            acc_en_q <= accumulate_i;
            cnt_q    <= '0;
            chunk_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          shift_q <= shift_q >> CHUNK_WIDTH;
          cnt_q   <= weight_d;
          chunk_q <= chunk_q + CIDX_W'(1);
          if (chunk_q == LAST_CHUNK) begin
            hw_q     <= weight_d;
            parity_q <= weight_d[0];
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
            // Overrides the plain clear above when both happen on this edge.
            if (acc_en_q) begin
              acc_q <= acc_d;
              ovf_q <= ovf_base | acc_sat;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign hammingWeight_o = hw_q;
  assign parity_o        = parity_q;
  assign accWeight_o     = acc_q;
  assign accOverflow_o   = ovf_q;

endmodule
